// File: rtl/scoreboard_regfile.sv
// Register file with per-register pending-write counters for in-order issue / out-of-order writeback.
// Optional same-cycle write-through forwarding on the read ports when SCOREBOARD_REGFILE_BYPASS_EN is defined.
module scoreboard_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_reg,
  output logic              rsv_stall,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_done,
  output logic              err_unexp_wr
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [DATA_W-1:0] regFile [NUM_REGS];
  logic [CNT_W-1:0]  pendCnt [NUM_REGS];
  logic [CNT_W-1:0]  nextCnt [NUM_REGS];
  logic [NUM_REGS-1:0] rsvHit;
  logic [NUM_REGS-1:0] wrHit;
  logic wrDoneQ;
  logic errQ;
  logic sameReg;
  logic rsvAccept;

  // Handshake: a reservation transfers on an edge where rsv_valid & ~rsv_stall; decode holds
  // rsv_reg while stalled. Writeback has no back-pressure: every wr_valid cycle transfers.
  assign sameReg   = wr_valid && (wr_reg == rsv_reg);
  assign rsv_stall = rsv_valid && (pendCnt[rsv_reg] == CntMax) && !sameReg;
  assign rsvAccept = rsv_valid && !rsv_stall;

  always_comb begin
    rsvHit = '0;
    wrHit  = '0;
    if (rsvAccept) rsvHit[rsv_reg] = 1'b1;
    if (wr_valid)  wrHit[wr_reg]   = 1'b1;
  end

  // A matching reserve and write cancel; otherwise saturate at max (stalled) and floor at 0 (error).
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      nextCnt[i] = pendCnt[i];
      if (rsvHit[i] && !wrHit[i]) begin
        nextCnt[i] = pendCnt[i] + CNT_W'(1);
      end else if (wrHit[i] && !rsvHit[i] && (pendCnt[i] != '0)) begin
        nextCnt[i] = pendCnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regFile[i] <= '0;
        pendCnt[i] <= '0;
      end
      wrDoneQ <= 1'b0;
      errQ    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        pendCnt[i] <= nextCnt[i];
        if (wrHit[i]) regFile[i] <= wr_data;
      end
      wrDoneQ <= wr_valid;
      if (wr_valid && (pendCnt[wr_reg] == '0)) errQ <= 1'b1;
    end
  end

  assign wr_done      = wrDoneQ;
  assign err_unexp_wr = errQ;

  always_comb begin
    rd_data1 = regFile[rd_addr1];
    rd_data2 = regFile[rd_addr2];
    rd_busy1 = (pendCnt[rd_addr1] != '0);
    rd_busy2 = (pendCnt[rd_addr2] != '0);
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
    // Forwarded reads report the count as it will be after this edge.
    if (wrHit[rd_addr1]) begin
      rd_data1 = wr_data;
      rd_busy1 = (nextCnt[rd_addr1] != '0);
    end
    if (wrHit[rd_addr2]) begin
      rd_data2 = wr_data;
      rd_busy2 = (nextCnt[rd_addr2] != '0);
    end
`endif
    if (rst) begin
      rd_data1 = '0;
      rd_data2 = '0;
      rd_busy1 = 1'b0;
      rd_busy2 = 1'b0;
    end
  end

endmodule

// File: doc/scoreboard_regfile.md
Name: scoreboard_regfile

Overview:
Parametrised successor to the 16x16 pipeline register file. It has N registers of DATA_W bits, two combinational read ports with per-register busy flags, and a clocked reservation port driven by decode. A clocked writeback port completes with a one-cycle done pulse. Per-register pending-write counters replace the single inuse bit, so back-to-back writers to the same destination (WAW) are tracked correctly. The block sits between the decode/operand-fetch stage and the writeback stage.

Parameters:
DATA_W, 16, register width in bits
NUM_REGS, 16, number of architectural registers (power of 2, >=2)
ADDR_W, 4, register index width; must equal log2(NUM_REGS)
CNT_W, 2, pending-write counter width; max outstanding writes per register = 2^CNT_W-1

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
rd_addr1  in  ADDR_W  read port 1 index
rd_addr2  in  ADDR_W  read port 2 index
rd_data1  out  DATA_W  contents of r[rd_addr1]
rd_data2  out  DATA_W  contents of r[rd_addr2]
rd_busy1  out  1  pending count of rd_addr1 is nonzero
rd_busy2  out  1  pending count of rd_addr2 is nonzero
rsv_valid  in  1  decode reserves rsv_reg as a destination this cycle
rsv_reg  in  ADDR_W  register to reserve
rsv_stall  out  1  combinational; reservation cannot be accepted this cycle
wr_valid  in  1  writeback presents a result this cycle
wr_reg  in  ADDR_W  destination index
wr_data  in  DATA_W  result value
wr_done  out  1  one-cycle pulse, cycle after an accepted write
err_unexp_wr  out  1  sticky; a write arrived for a register with pending count 0

Behaviour:
- Reset (async, on rst high): all r[i]=0, all cnt[i]=0, wr_done=0, err_unexp_wr=0. While rst is high, rd_busy*=0 and rd_data*=0. A reservation or write in the reset cycle is discarded.
- Reads: combinational, zero latency. rd_data/rd_busy reflect registered state, pre-edge values. With the bypass disabled there is no same-cycle forwarding.
- rsv_stall = rsv_valid & (cnt[rsv_reg]==2^CNT_W-1) & ~(wr_valid & wr_reg==rsv_reg). A stalled reservation has no effect, and decode must hold it.
- Accepted reservation (rsv_valid & ~rsv_stall): cnt[rsv_reg] increments at the next posedge.
- Write (wr_valid), always accepted: r[wr_reg]<=wr_data at posedge.
  - cnt[wr_reg] decrements if nonzero.
  - If cnt is 0, cnt stays 0 and err_unexp_wr is set (sticky until rst).
  - wr_done=1 in the following cycle only. Back-to-back writes give back-to-back done pulses.
- Same-register reservation and write in the same cycle: the counter is unchanged (+1-1). Data is written. Not a stall, even at max count.
- Different-register reservation and write in the same cycle: both update independently.
- Counter never wraps: no increment at max (stall), no decrement at 0 (error).
- rd_addr1==rd_addr2 is legal; both ports return identical values.
- All indices are in range by construction (NUM_REGS=2^ADDR_W), so no out-of-range handling.
- Reset asserted mid-operation clears all counters. Writes in flight at reset are lost, and the pipeline must flush.

Optional Feature:
Macro SCOREBOARD_REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If wr_valid and wr_reg==rd_addrN, then rd_dataN=wr_data in the same cycle. rd_busyN reflects the post-write count, i.e. it is 0 if cnt[wr_reg]<=1 and no same-register reservation is accepted that cycle.
- Undefined: reads show pre-edge state only, and the consumer sees the value one cycle later.

Test Plan:
- Reset then read: rst pulse; rd_addr1=3, rd_addr2=15 -> rd_data*=0, rd_busy*=0, err_unexp_wr=0.
- Reserve/write round trip: rsv R3 at cycle 0 -> rd_busy1(R3)=1 from cycle 1. Write R3=0xBEEF at cycle 2 -> rd_data1=0xBEEF, rd_busy1=0, wr_done=1 at cycle 3 and 0 at cycle 4.
- WAW: reserve R5 at cycles 0 and 1 (cnt=2). Write R5=0x1111 -> busy still 1. Write R5=0x2222 -> busy 0, data 0x2222.
- Saturation (CNT_W=2): three reservations of R7, fourth held -> rsv_stall=1 and count stays 3. Same cycle with wr_valid R7 -> rsv_stall=0, count stays 3.
- Unexpected write: write R9=0x00AA with cnt 0 -> r9=0x00AA, err_unexp_wr=1 and held until rst.
- Bypass (macro defined): cnt[R2]=1; wr_valid R2=0x1234 with rd_addr1=2 -> same-cycle rd_data1=0x1234, rd_busy1=0. Macro undefined -> old value, busy=1 that cycle.
